// File: rtl/ram_bist_pkg.sv
// Shared types and test pattern for the 4x4 RAM BIST.
// Optional feature macro used by this slice: RAM_BIST_ERR_COUNT_EN.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR0,
      RD0,
      WR1,
      RD1,
      DRAIN,
      DONE
   } state_t;

   // Phase-0 pattern: upper bits are the inverted address, lower bits the
   // address itself, so every cell holds a different word (C,9,6,3).
   // The phase-1 pattern is the bitwise inverse of this.
   function automatic logic [3:0] p0(input logic [1:0] a);
      return {~a, a};
   endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for the RAM BIST: registers what each read cycle should
// return, compares it against Dout one cycle later and keeps the run result.
// Optional feature macro: RAM_BIST_ERR_COUNT_EN adds a mismatch counter.
module ram_bist_cmp (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       rdValid,
   input  logic [1:0] rdAddr,
   input  logic       rdPhase,
   input  logic [3:0] expData,
   input  logic [3:0] Dout,
   output logic       pass,
   output logic [1:0] err_addr,
   output logic       err_phase
`ifdef RAM_BIST_ERR_COUNT_EN
   ,
   output logic [3:0] err_cnt
`endif
);

   logic       cmpValid;
   logic [3:0] cmpExp;
   logic [1:0] cmpAddr;
   logic       cmpPhase;
   logic       errSeen;
   logic       mismatch;

   // The RAM answers a read one edge later, so hold the expectation for a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmpValid <= 1'b0;
         cmpExp   <= 4'd0;
         cmpAddr  <= 2'd0;
         cmpPhase <= 1'b0;
      end else begin
         cmpValid <= rdValid;
         cmpExp   <= expData;
         cmpAddr  <= rdAddr;
         cmpPhase <= rdPhase;
      end
   end

   // A mismatch only counts while a delayed read is actually pending.
   always_comb begin
      mismatch = cmpValid && (Dout != cmpExp);
   end

   // Run result: pass starts optimistic, first failing location is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass      <= 1'b0;
         err_addr  <= 2'd0;
         err_phase <= 1'b0;
         errSeen   <= 1'b0;
      end else if (clear) begin
         pass      <= 1'b1;
         err_addr  <= 2'd0;
         err_phase <= 1'b0;
         errSeen   <= 1'b0;
      end else if (mismatch) begin
         pass    <= 1'b0;
         errSeen <= 1'b1;
         if (!errSeen) begin
            err_addr  <= cmpAddr;
            err_phase <= cmpPhase;
         end
      end
   end

`ifdef RAM_BIST_ERR_COUNT_EN
   // Mismatch tally for the current run; at most eight reads, so no wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 4'd0;
      end else if (clear) begin
         err_cnt <= 4'd0;
      end else if (mismatch) begin
         err_cnt <= err_cnt + 4'd1;
      end
   end
`endif

endmodule

// File: rtl/ram_bist_4x4.sv
// March-style BIST for a 4-word x 4-bit RAM: write P0, read P0, write ~P0,
// read ~P0, then drain the last read and pulse done.
// Optional feature macro: RAM_BIST_ERR_COUNT_EN exposes err_cnt.
module ram_bist_4x4
   import ram_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] err_addr,
   output logic       err_phase,
   output logic [1:0] Addr,
   output logic       SEL,
   output logic [3:0] Din,
   input  logic [3:0] Dout
`ifdef RAM_BIST_ERR_COUNT_EN
   ,
   output logic [3:0] err_cnt
`endif
);

   state_t     state;
   state_t     stateNext;
   logic [1:0] addrCnt;
   logic [1:0] addrNext;
   logic       runStart;
   logic       rdValid;
   logic       rdPhase;
   logic [3:0] expData;

   // State and address counter; reset lands in IDLE so SEL falls immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addrCnt <= 2'd0;
      end else begin
         state   <= stateNext;
         addrCnt <= addrNext;
      end
   end

   // Sequencing: each march element walks addresses 0..3, then moves on.
   always_comb begin
      stateNext = state;
      addrNext  = addrCnt;
      case (state)
         IDLE: begin
            addrNext = 2'd0;
            if (start) stateNext = WR0;
         end
         WR0: begin
            addrNext = addrCnt + 2'd1;
            if (addrCnt == 2'd3) stateNext = RD0;
         end
         RD0: begin
            addrNext = addrCnt + 2'd1;
            if (addrCnt == 2'd3) stateNext = WR1;
         end
         WR1: begin
            addrNext = addrCnt + 2'd1;
            if (addrCnt == 2'd3) stateNext = RD1;
         end
         RD1: begin
            addrNext = addrCnt + 2'd1;
            if (addrCnt == 2'd3) stateNext = DRAIN;
         end
         DRAIN:   stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // RAM drive and status decode, purely from the current state.
   always_comb begin
      Addr     = 2'd0;
      SEL      = 1'b0;
      Din      = 4'd0;
      rdValid  = 1'b0;
      rdPhase  = 1'b0;
      expData  = 4'd0;
      busy     = (state != IDLE) && (state != DONE);
      done     = (state == DONE);
      runStart = (state == IDLE) && start;
      case (state)
         WR0: begin
            Addr = addrCnt;
            SEL  = 1'b1;
            Din  = p0(addrCnt);
         end
         RD0: begin
            Addr    = addrCnt;
            rdValid = 1'b1;
            expData = p0(addrCnt);
         end
         WR1: begin
            Addr = addrCnt;
            SEL  = 1'b1;
            Din  = ~p0(addrCnt);
         end
         RD1: begin
            Addr    = addrCnt;
            rdValid = 1'b1;
            rdPhase = 1'b1;
            expData = ~p0(addrCnt);
         end
         default: begin
            Addr = 2'd0;
         end
      endcase
   end

   ram_bist_cmp cmpInst (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (runStart),
      .rdValid   (rdValid),
      .rdAddr    (addrCnt),
      .rdPhase   (rdPhase),
      .expData   (expData),
      .Dout      (Dout),
      .pass      (pass),
      .err_addr  (err_addr),
      .err_phase (err_phase)
`ifdef RAM_BIST_ERR_COUNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

endmodule
